// File: rtl/stage_sequencer_if.sv
// Bundle between the stage sequencer and its host / velocity unit.
// slave: sequencer side (table writes, launch/abort, burnout flag in;
//        engine row, re-arm, separation strobe, status out).
// master: host / velocity-unit side, directions mirrored.
interface stage_sequencer_if #(
    parameter int W = 64
);
    logic         cfg_we;
    logic [1:0]   cfg_stage;
    logic [1:0]   cfg_field;
    logic [W-1:0] cfg_data;
    logic         launch;
    logic         abort;
    logic         dir_backward;
    logic         ignition_end;
    logic [W-1:0] velocity_in;
    logic         eng_resetb;
    logic         eng_backward;
    logic [W-1:0] eng_isp;
    logic [W-1:0] eng_m0;
    logic [W-1:0] eng_mp;
    logic [W-1:0] eng_tb;
    logic         sep_pulse;
    logic [1:0]   stage_idx;
    logic [W-1:0] burnout_v;
    logic         busy;
    logic         done;
    logic         fault;

    modport slave (
        input  cfg_we, cfg_stage, cfg_field, cfg_data,
        input  launch, abort, dir_backward,
        input  ignition_end, velocity_in,
        output eng_resetb, eng_backward,
        output eng_isp, eng_m0, eng_mp, eng_tb,
        output sep_pulse, stage_idx, burnout_v,
        output busy, done, fault
    );

    modport master (
        output cfg_we, cfg_stage, cfg_field, cfg_data,
        output launch, abort, dir_backward,
        output ignition_end, velocity_in,
        input  eng_resetb, eng_backward,
        input  eng_isp, eng_m0, eng_mp, eng_tb,
        input  sep_pulse, stage_idx, burnout_v,
        input  busy, done, fault
    );
endinterface

// File: rtl/stage_sequencer.sv
// Flight-sequence controller: per-stage table, arm/burn/coast/separate loop.
// Ports: clk, reset (async, active-high), bus (stage_sequencer_if.slave).
module stage_sequencer #(
    parameter int N_STAGES  = 3,
    parameter int W         = 64,
    parameter int COAST_CYC = 1000,
    parameter int BURN_TMO  = 2**20
) (
    input  logic             clk,
    input  logic             reset,
    stage_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_BURN, S_COAST, S_SEP, S_DONE, S_FAULT
    } state_t;

    state_t       state_q;
    logic [W-1:0] tbl_q [4][4];
    logic [W-1:0] tbl_d [4][4];
    logic [31:0]  cnt_q;
    logic [1:0]   stage_q;
    logic         launch_q;
    logic         resetb_q, backward_q, sep_q;
    logic         busy_q, done_q, fault_q;
    logic [W-1:0] isp_q, m0_q, mp_q, tb_q, bov_q;

    logic         wr_ok, abort_hit, arm_en, last_stage;
    logic         ign_ok, tmo_hit, coast_end;
    logic [1:0]   arm_idx;
    logic [31:0]  cnt_inc;

    // Same-cycle write is forwarded so a launch in that cycle arms with it.
    always_comb begin
        tbl_d = tbl_q;
        wr_ok = (state_q == S_IDLE) && bus.cfg_we
              && ({30'd0, bus.cfg_stage} < 32'(N_STAGES));
        if (wr_ok) begin
            tbl_d[bus.cfg_stage][bus.cfg_field] = bus.cfg_data;
        end
    end

    assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    // First BURN cycle has cnt_q==0: a stale burnout flag is ignored there.
    assign ign_ok     = bus.ignition_end && (cnt_q != '0);
    assign tmo_hit    = (BURN_TMO != 0) && (cnt_inc == 32'(BURN_TMO));
    assign coast_end  = (cnt_inc >= 32'(COAST_CYC));
    assign last_stage = ({30'd0, stage_q} >= 32'(N_STAGES - 1));
    assign abort_hit  = bus.abort && (state_q inside
                        {S_ARM, S_BURN, S_COAST, S_SEP, S_DONE});
    assign arm_idx    = (state_q == S_SEP) ? stage_q + 2'd1 : 2'd0;
    assign arm_en     = !abort_hit && (
                        (state_q == S_IDLE && bus.launch) ||
                        (state_q == S_DONE && bus.launch && !launch_q) ||
                        (state_q == S_SEP && !last_stage));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int r = 0; r < 4; r++) begin
                for (int f = 0; f < 4; f++) begin
                    tbl_q[r][f] <= '0;
                end
            end
            cnt_q      <= '0;
            stage_q    <= '0;
            launch_q   <= 1'b0;
            resetb_q   <= 1'b0;
            backward_q <= 1'b0;
            sep_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            isp_q      <= '0;
            m0_q       <= '0;
            mp_q       <= '0;
            tb_q       <= '0;
            bov_q      <= '0;
        end else begin
            tbl_q    <= tbl_d;
            launch_q <= bus.launch;
            sep_q    <= 1'b0;
            if (abort_hit) begin
                state_q  <= S_IDLE;
                resetb_q <= 1'b0;
                done_q   <= 1'b0;
                busy_q   <= 1'b0;
            end else if (arm_en) begin
                state_q    <= S_ARM;
                stage_q    <= arm_idx;
                isp_q      <= tbl_d[arm_idx][0];
                m0_q       <= tbl_d[arm_idx][1];
                mp_q       <= tbl_d[arm_idx][2];
                tb_q       <= tbl_d[arm_idx][3];
                backward_q <= bus.dir_backward;
                resetb_q   <= 1'b0;
                busy_q     <= 1'b1;
                done_q     <= 1'b0;
                fault_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    S_ARM: begin
                        state_q  <= S_BURN;
                        cnt_q    <= '0;
                        resetb_q <= 1'b1;
                    end
                    S_BURN: begin
                        cnt_q <= cnt_inc;
                        if (ign_ok) begin
                            bov_q   <= bus.velocity_in;
                            state_q <= S_COAST;
                            cnt_q   <= '0;
                        end else if (tmo_hit) begin
                            state_q  <= S_FAULT;
                            fault_q  <= 1'b1;
                            resetb_q <= 1'b0;
                            busy_q   <= 1'b0;
                        end
                    end
                    S_COAST: begin
                        cnt_q <= cnt_inc;
                        if (coast_end) begin
                            state_q <= S_SEP;
                            sep_q   <= 1'b1;
                        end
                    end
                    // Not re-armed above, so this was the last stage.
                    S_SEP: begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.eng_resetb   = resetb_q;
    assign bus.eng_backward = backward_q;
    assign bus.eng_isp      = isp_q;
    assign bus.eng_m0       = m0_q;
    assign bus.eng_mp       = mp_q;
    assign bus.eng_tb       = tb_q;
    assign bus.sep_pulse    = sep_q;
    assign bus.stage_idx    = stage_q;
    assign bus.burnout_v    = bov_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.fault        = fault_q;

endmodule
